// File: rtl/spi_flash_pkg.sv
// rtl/spi_flash_pkg.sv - shared constants and FSM encoding for the SPI flash reader
package spi_flash_pkg;

  localparam logic [7:0] READ_OPCODE       = 8'h03;
  localparam int         ADDR_W            = 24;
  localparam int         SCLK_HALF_DEFAULT = 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DATA,
    ST_STALL,
    ST_FINISH,
    ST_GAP
  } state_t;

endpackage

// File: rtl/spi_bit_engine.sv
// rtl/spi_bit_engine.sv - SCLK divider plus MSB-first shift register for mode-0 SPI
module spi_bit_engine
  import spi_flash_pkg::*;
#(
  parameter int SCLK_HALF = SCLK_HALF_DEFAULT
) (
  input  logic              clock_12mhz,
  input  logic              reset,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_word,
  input  logic [4:0]        load_bits,
  input  logic              run,
  input  logic              miso,
  output logic              sclk,
  output logic              mosi,
  output logic [7:0]        rx_byte,
  output logic              shift_done
);

  localparam int DIV_W = (SCLK_HALF > 1) ? $clog2(SCLK_HALF) : 1;

  logic [DIV_W-1:0]  div;
  logic [ADDR_W-1:0] sh;
  logic [4:0]        bits;
  logic              active;
  logic              edge_now;

  assign edge_now   = active && run && (div == DIV_W'(SCLK_HALF - 1));
  // Strobe on the final falling edge so the next segment can load without a gap.
  assign shift_done = edge_now && sclk && (bits == 5'd1);

  always_ff @(posedge clock_12mhz) begin
    if (reset) begin
      div     <= '0;
      sh      <= '0;
      bits    <= '0;
      active  <= 1'b0;
      sclk    <= 1'b0;
      mosi    <= 1'b0;
      rx_byte <= '0;
    end else if (load && !active) begin
      sh     <= load_word;
      mosi   <= load_word[ADDR_W-1];
      bits   <= load_bits;
      active <= 1'b1;
      div    <= '0;
      sclk   <= 1'b0;
    end else if (edge_now) begin
      div  <= '0;
      sclk <= !sclk;
      if (sclk) begin
        rx_byte <= {rx_byte[6:0], miso};
        if (bits == 5'd1) begin
          if (load) begin
            sh   <= load_word;
            mosi <= load_word[ADDR_W-1];
            bits <= load_bits;
          end else begin
            active <= 1'b0;
            mosi   <= 1'b0;
          end
        end else begin
          sh   <= {sh[ADDR_W-2:0], 1'b0};
          mosi <= sh[ADDR_W-2];
          bits <= bits - 5'd1;
        end
      end
    end else if (active && run) begin
      div <= div + DIV_W'(1);
    end
  end

endmodule

// File: rtl/spi_flash_reader.sv
// rtl/spi_flash_reader.sv - READ (0x03) controller streaming flash bytes over valid/ready
module spi_flash_reader
  import spi_flash_pkg::*;
#(
  parameter int SCLK_HALF = SCLK_HALF_DEFAULT,
  parameter int LEN_W     = 16,
  parameter int CS_GAP    = 4
) (
  input  logic              clock_12mhz,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] addr,
  input  logic [LEN_W-1:0]  len,
  output logic              busy,
  output logic              done,
  output logic [7:0]        data,
  output logic              data_valid,
  input  logic              data_ready,
  output logic              flash_cs,
  output logic              flash_sclk,
  output logic              flash_mosi,
  input  logic              flash_miso
);

  localparam int GAP_W = $clog2(CS_GAP + 1);

  state_t            state;
  logic [ADDR_W-1:0] addr_q;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  cnt;
  logic [GAP_W-1:0]  gap_cnt;
  logic              byte_pending;
  logic              last_byte;
  logic              eng_load;
  logic [ADDR_W-1:0] eng_word;
  logic [4:0]        eng_bits;
  logic              eng_run;
  logic              shift_done;
  logic [7:0]        rx_byte;

  assign last_byte = (cnt + LEN_W'(1)) == len_q;
  // Freeze SCLK as soon as a finished byte cannot be handed over.
  assign eng_run   = (state != ST_STALL) &&
                     !(state == ST_DATA && byte_pending && data_valid && !data_ready);

  always_comb begin
    eng_load = 1'b0;
    eng_word = '0;
    eng_bits = 5'd8;
    case (state)
      ST_IDLE: if (start && len != '0) begin
        eng_load = 1'b1;
        eng_word = {READ_OPCODE, {(ADDR_W-8){1'b0}}};
      end
      ST_CMD: if (shift_done) begin
        eng_load = 1'b1;
        eng_word = addr_q;
        eng_bits = 5'd24;
      end
      ST_ADDR: eng_load = shift_done;
      ST_DATA: eng_load = shift_done && !last_byte;
      default: ;
    endcase
  end

  spi_bit_engine #(.SCLK_HALF(SCLK_HALF)) u_engine (
    .clock_12mhz (clock_12mhz),
    .reset       (reset),
    .load        (eng_load),
    .load_word   (eng_word),
    .load_bits   (eng_bits),
    .run         (eng_run),
    .miso        (flash_miso),
    .sclk        (flash_sclk),
    .mosi        (flash_mosi),
    .rx_byte     (rx_byte),
    .shift_done  (shift_done)
  );

  always_ff @(posedge clock_12mhz) begin
    if (reset) begin
      state        <= ST_IDLE;
      addr_q       <= '0;
      len_q        <= '0;
      cnt          <= '0;
      gap_cnt      <= '0;
      byte_pending <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      data         <= '0;
      data_valid   <= 1'b0;
      flash_cs     <= 1'b1;
    end else begin
      done <= 1'b0;
      if (data_valid && data_ready) data_valid <= 1'b0;
      case (state)
        ST_IDLE: if (start) begin
          addr_q  <= addr;
          len_q   <= len;
          cnt     <= '0;
          gap_cnt <= '0;
          busy    <= 1'b1;
          if (len == '0) begin
            state <= ST_GAP;
          end else begin
            flash_cs <= 1'b0;
            state    <= ST_CMD;
          end
        end
        ST_CMD:  if (shift_done) state <= ST_ADDR;
        ST_ADDR: if (shift_done) state <= ST_DATA;
        ST_DATA: begin
          if (shift_done) begin
            byte_pending <= 1'b1;
            cnt          <= cnt + LEN_W'(1);
          end
          if (byte_pending) begin
            if (!data_valid || data_ready) begin
              data         <= rx_byte;
              data_valid   <= 1'b1;
              byte_pending <= 1'b0;
              if (cnt == len_q) begin
                flash_cs <= 1'b1;
                state    <= ST_FINISH;
              end
            end else begin
              state <= ST_STALL;
            end
          end
        end
        ST_STALL: if (data_ready) begin
          data         <= rx_byte;
          data_valid   <= 1'b1;
          byte_pending <= 1'b0;
          if (cnt == len_q) begin
            flash_cs <= 1'b1;
            state    <= ST_FINISH;
          end else begin
            state <= ST_DATA;
          end
        end
        ST_FINISH: if (!data_valid) begin
          gap_cnt <= '0;
          state   <= ST_GAP;
        end
        ST_GAP: begin
          if (gap_cnt == GAP_W'(CS_GAP - 1)) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= ST_IDLE;
          end else begin
            gap_cnt <= gap_cnt + GAP_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
